// File: rtl/rate_counter.sv
// Run/pause up/down hex digit counter stepped by a speed-selectable rate divider.
// Optional wrap carry pulse is built only when RATE_COUNTER_CARRY_EN is defined.
module rate_counter #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned DIV_W  = 28
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic [1:0]       speed,
    input  logic             up,
    input  logic             load,
    input  logic [3:0]       load_val,
    input  logic             pause_key_n,
    output logic [3:0]       digit,
    output logic             tick,
    output logic             running,
    output logic             carry
);

    localparam logic [DIV_W-1:0] RELOAD_0 = '0;
    localparam logic [DIV_W-1:0] RELOAD_1 = DIV_W'(CLK_HZ - 1);
    localparam logic [DIV_W-1:0] RELOAD_2 = DIV_W'(2 * CLK_HZ - 1);
    localparam logic [DIV_W-1:0] RELOAD_3 = DIV_W'(4 * CLK_HZ - 1);

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t           state;
    logic             sync1;
    logic             sync2;
    logic             key_prev;
    logic             key_fall_c;
    logic [1:0]       speed_q;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] reload_c;
    logic             speed_chg_c;
    logic             step_c;

    // Divider reload value for the currently selected speed
    always_comb begin
        reload_c = RELOAD_1;
        case (speed)
            2'b00:   reload_c = RELOAD_0;
            2'b01:   reload_c = RELOAD_1;
            2'b10:   reload_c = RELOAD_2;
            default: reload_c = RELOAD_3;
        endcase
    end

    assign key_fall_c  = key_prev & ~sync2;
    assign speed_chg_c = (speed != speed_q);
    // A step is suppressed by load, a speed change, or the edge that pauses
    assign step_c      = (state == RUN) && !key_fall_c && !load && !speed_chg_c
                         && (div_cnt == '0);
    assign running     = (state == RUN);

    // Button synchronizer and falling-edge history
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            key_prev <= 1'b1;
        end else begin
            sync1    <= pause_key_n;
            sync2    <= sync1;
            key_prev <= sync2;
        end
    end

    // Run/pause FSM, rate divider and digit
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state   <= PAUSE;
            speed_q <= 2'b01;
            div_cnt <= RELOAD_1;
            digit   <= 4'd0;
            tick    <= 1'b0;
        end else begin
            speed_q <= speed;
            tick    <= step_c;
            if (key_fall_c) begin
                state <= (state == RUN) ? PAUSE : RUN;
            end
            if (load) begin
                digit   <= load_val;
                div_cnt <= reload_c;
            end else if (speed_chg_c) begin
                div_cnt <= reload_c;
            end else if (state == PAUSE) begin
                // Entering RUN restarts a full period
                if (key_fall_c) begin
                    div_cnt <= reload_c;
                end
            end else if (step_c) begin
                digit   <= up ? (digit + 4'd1) : (digit - 4'd1);
                div_cnt <= reload_c;
            end else if (!key_fall_c) begin
                div_cnt <= div_cnt - DIV_W'(1);
            end
        end
    end

`ifdef RATE_COUNTER_CARRY_EN
    logic wrap_c;

    assign wrap_c = up ? (digit == 4'hF) : (digit == 4'h0);

    // Carry coincides with the tick that wraps the digit
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            carry <= 1'b0;
        end else begin
            carry <= step_c && wrap_c;
        end
    end
`else
    assign carry = 1'b0;
`endif

endmodule

// File: tb/tb_rate_counter.sv
// Directed bench for rate_counter with CLK_HZ=4; carry expectations follow RATE_COUNTER_CARRY_EN.
module tb_rate_counter;

    localparam int unsigned CLK_HZ = 4;
    localparam int unsigned DIV_W  = 5;
`ifdef RATE_COUNTER_CARRY_EN
    localparam logic CARRY_ON = 1'b1;
`else
    localparam logic CARRY_ON = 1'b0;
`endif

    logic       clk;
    logic       resetn;
    logic [1:0] speed;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic       pause_key_n;
    logic [3:0] digit;
    logic       tick;
    logic       running;
    logic       carry;

    int tests;
    int fails;
    int n;
    int tick_seen;

    rate_counter #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (DIV_W)
    ) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .speed       (speed),
        .up          (up),
        .load        (load),
        .load_val    (load_val),
        .pause_key_n (pause_key_n),
        .digit       (digit),
        .tick        (tick),
        .running     (running),
        .carry       (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts falling edges until tick is seen high, bounded by limit
    task automatic wait_tick(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (tick !== 1'b1 && cycles < limit);
        if (tick !== 1'b1) check("tick_timeout", 32'(tick), 32'd1);
    endtask

    task automatic press();
        pause_key_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        resetn      = 1'b0;
        speed       = 2'b01;
        up          = 1'b1;
        load        = 1'b0;
        load_val    = 4'h0;
        pause_key_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Press: running rises three edges after the key goes low
        pause_key_n = 1'b0;
        @(negedge clk);
        check("press_e1", 32'(running), 32'd0);
        @(negedge clk);
        check("press_e2", 32'(running), 32'd0);
        @(negedge clk);
        check("press_e3", 32'(running), 32'd1);
        pause_key_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_tick(40, n);
            check("tick_period", 32'(n), 32'd4);
            check("count_up", 32'(digit), 32'(k));
        end
        @(negedge clk);
        check("tick_pulse_width", 32'(tick), 32'd0);

        // Load F then wrap to 0 with carry
        load_val = 4'hF;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("load_f_digit", 32'(digit), 32'hF);
        check("load_f_tick", 32'(tick), 32'd0);
        wait_tick(40, n);
        check("wrap_up_period", 32'(n), 32'd4);
        check("wrap_up_digit", 32'(digit), 32'd0);
        check("wrap_up_carry", 32'(carry), 32'(CARRY_ON));
        @(negedge clk);
        check("carry_width", 32'(carry), 32'd0);

        // Count down every cycle from 0
        up    = 1'b0;
        speed = 2'b00;
        @(negedge clk);
        check("speed_chg_no_tick", 32'(tick), 32'd0);
        check("speed_chg_digit", 32'(digit), 32'd0);
        @(negedge clk);
        check("down_f", 32'(digit), 32'hF);
        check("down_f_carry", 32'(carry), 32'(CARRY_ON));
        @(negedge clk);
        check("down_e", 32'(digit), 32'hE);
        check("down_e_carry", 32'(carry), 32'd0);
        @(negedge clk);
        check("down_d", 32'(digit), 32'hD);
        check("down_d_tick", 32'(tick), 32'd1);

        // Held press pauses once; digit freezes at B
        press();
        check("pause_running", 32'(running), 32'd0);
        check("pause_digit", 32'(digit), 32'hB);
        repeat (17) @(negedge clk);
        check("held_running", 32'(running), 32'd0);
        check("held_digit", 32'(digit), 32'hB);
        check("held_tick", 32'(tick), 32'd0);
        pause_key_n = 1'b1;
        repeat (5) @(negedge clk);
        check("release_running", 32'(running), 32'd0);
        press();
        pause_key_n = 1'b1;
        check("resume_running", 32'(running), 32'd1);
        @(negedge clk);
        check("resume_digit", 32'(digit), 32'hA);
        check("resume_tick", 32'(tick), 32'd1);

        // Speed 01 -> 11 mid-period
        speed = 2'b01;
        up    = 1'b1;
        @(negedge clk);
        check("to_s01_tick", 32'(tick), 32'd0);
        check("to_s01_digit", 32'(digit), 32'hA);
        repeat (2) @(negedge clk);
        speed = 2'b11;
        @(negedge clk);
        check("to_s11_tick", 32'(tick), 32'd0);
        wait_tick(40, n);
        check("s11_period", 32'(n), 32'd16);
        check("s11_digit", 32'(digit), 32'hB);

        // Load coincident with an expiring divider
        speed = 2'b00;
        @(negedge clk);
        load_val = 4'h7;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("load_vs_tick_digit", 32'(digit), 32'h7);
        check("load_vs_tick_tick", 32'(tick), 32'd0);
        check("load_vs_tick_run", 32'(running), 32'd1);
        @(negedge clk);
        check("after_load_digit", 32'(digit), 32'h8);
        check("after_load_tick", 32'(tick), 32'd1);

        // Async reset mid-run at digit 5
        speed    = 2'b01;
        load_val = 4'h5;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("pre_rst_digit", 32'(digit), 32'h5);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_digit", 32'(digit), 32'd0);
        check("async_rst_running", 32'(running), 32'd0);
        check("async_rst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        resetn    = 1'b1;
        tick_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (tick === 1'b1) tick_seen++;
        end
        check("post_rst_ticks", 32'(tick_seen), 32'd0);
        check("post_rst_running", 32'(running), 32'd0);
        check("post_rst_digit", 32'(digit), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rate_counter.md
RATE_COUNTER -- requirements
Module: rate_counter

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clock cycles per second; benches set it small (e.g. 4).
REQ-002 Parameter DIV_W, default 28, rate-divider width; SHALL hold 4*CLK_HZ-1.
REQ-003 CLOCK_50  input  1  system clock; all state on its rising edge.
REQ-004 resetn  input  1  reset; asynchronous, active-low.
REQ-005 speed  input  2  tick-rate select (SW[1:0]).
REQ-006 up  input  1  count direction: 1 = up, 0 = down.
REQ-007 load  input  1  synchronous parallel-load request, active-high.
REQ-008 load_val  input  4  value loaded into digit.
REQ-009 pause_key_n  input  1  raw push button, active-low, asynchronous to clock; each press toggles run/pause.
REQ-010 digit  output  4  current count; feeds the 7-segment hex decoder input c[3:0].
REQ-011 tick  output  1  one-cycle pulse when the divider expires in RUN.
REQ-012 running  output  1  1 in RUN state, 0 in PAUSE.
REQ-013 carry  output  1  one-cycle pulse on digit wrap (see Configuration).

Function
REQ-014 Divider reload value SHALL be 0 for speed=00, CLK_HZ-1 for 01, 2*CLK_HZ-1 for 10, 4*CLK_HZ-1 for 11.
REQ-015 In RUN the divider SHALL decrement each cycle; at 0 it SHALL assert tick that cycle and reload on the next edge; speed=00 gives tick every cycle.
REQ-016 Tick period SHALL therefore be reload+1 cycles (speed=01: 1 s at default CLK_HZ).
REQ-017 On each tick digit SHALL step by +1 (up=1) or -1 (up=0), modulo 16.
REQ-018 Wrap: F->0 counting up and 0->F counting down SHALL each assert carry in the same cycle as the stepping tick.
REQ-019 In PAUSE the divider and digit SHALL hold; tick and carry SHALL be 0.
REQ-020 A change of speed SHALL reload the divider with the new value on the next edge; no tick in that cycle.
REQ-021 load=1 SHALL write load_val to digit and reload the divider on the next edge, in either state, with priority over tick; tick and carry SHALL be 0 that cycle; run state unchanged.
REQ-022 pause_key_n SHALL pass through a two-flop synchronizer followed by a falling-edge detector.
REQ-023 FSM states PAUSE and RUN; each detected falling edge toggles the state, exactly once per press regardless of hold length.
REQ-024 running SHALL change on the third rising edge after the first edge that samples pause_key_n low.
REQ-025 On PAUSE->RUN the divider SHALL reload, so the first tick occurs reload+1 cycles after running rises.
REQ-026 A change of up SHALL take effect on the next tick; no reload.
REQ-027 All outputs SHALL be registered or decoded from registers only; no combinational path from any input to any output.

Reset
REQ-028 resetn=0 SHALL immediately force digit=0, tick=0, carry=0, running=0 (PAUSE), divider to speed=01 reload value, synchronizer flops to 1.
REQ-029 Reset asserted mid-count SHALL abort counting with no tick or carry emitted; operation resumes in PAUSE after release.

Configuration
REQ-030 Macro RATE_COUNTER_CARRY_EN: when defined, carry SHALL behave per REQ-018.
REQ-031 When undefined, carry SHALL be tied to 0 and no wrap-detect logic is built; all other behaviour identical.

Verification (CLK_HZ=4)
REQ-032 Reset, speed=01, up=1, one press -> running=1 three edges later; tick every 4 cycles; digit 0,1,2,3.
REQ-033 load_val=F, load pulse, up=1, RUN -> digit=F, next tick digit=0 with carry=1 (0 when RATE_COUNTER_CARRY_EN undefined).
REQ-034 up=0 from digit=0, speed=00 -> digit F,E,D on consecutive cycles; carry=1 only on 0->F.
REQ-035 Held press of 20 cycles, then a second press -> exactly two toggles; digit frozen while paused.
REQ-036 speed 01->11 mid-period -> next tick exactly 16 cycles after the change; load coincident with tick -> load_val wins, tick=0.
REQ-037 resetn low mid-RUN at digit=5 -> digit=0, running=0 immediately, no tick until a new press.
